// File: rtl/gl_fb_writer_if.sv
// +----------------------------------------------------------------------------+
// | gl_fb_writer_if : 32-bit req/ack write port between FBWriter and memory    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface gl_fb_writer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, output mem_data, output mem_be,
                  input  mem_ack);
  modport slave  (input  mem_req, input  mem_addr, input  mem_data, input  mem_be,
                  output mem_ack);
endinterface

`default_nettype wire

// File: rtl/gl_fb_writer.sv
// +----------------------------------------------------------------------------+
// | gl_fb_writer : pops rasterizer pixels, range-checks them and writes them   |
// | to the framebuffer; also performs whole-frame clears.                      |
// | Optional macro GL_FB_CLIP_COUNT_EN adds the clip_count output.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module gl_fb_writer #(
  parameter int unsigned FB_WIDTH   = 640,
  parameter int unsigned FB_HEIGHT  = 480,
  parameter logic [31:0] FB_BASE    = 32'h0000_0000
`ifdef GL_FB_CLIP_COUNT_EN
  ,
  parameter int unsigned CLIP_CNT_W = 16
`endif
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic [95:0]   pix_fifo_dout,
  input  wire logic          pix_fifo_empty,
  output logic               pix_fifo_rd_en,
  input  wire logic          clear_start,
  input  wire logic [31:0]   clear_color,
  output logic               busy,
  gl_fb_writer_if.master     mem
`ifdef GL_FB_CLIP_COUNT_EN
  ,
  output logic [CLIP_CNT_W-1:0] clip_count
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    CALC      = 3'd2,
    WRITE     = 3'd3,
    CLEAR     = 3'd4
  } state_t;

  localparam logic [31:0] PIX_LAST = FB_WIDTH * FB_HEIGHT - 1;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] rgb_q, rgb_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        in_range;
  logic [31:0] lin_idx;

  assign in_range = (x_q < FB_WIDTH) && (y_q < FB_HEIGHT);
  assign lin_idx  = y_q * FB_WIDTH + x_q;

`ifdef GL_FB_CLIP_COUNT_EN
  logic                  clip_inc;
  logic [CLIP_CNT_W-1:0] clip_q, clip_d;
`endif

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    rgb_d          = rgb_q;
    idx_d          = idx_q;
    addr_d         = addr_q;
    data_d         = data_q;
    pix_fifo_rd_en = 1'b0;
`ifdef GL_FB_CLIP_COUNT_EN
    clip_inc       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          addr_d  = FB_BASE;
          data_d  = clear_color;
          idx_d   = 32'd0;
          state_d = CLEAR;
        end else if (!pix_fifo_empty) begin
          // Combinational pop: keep it quiet while reset holds the FSM in IDLE.
          pix_fifo_rd_en = !reset;
          state_d        = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        x_d     = pix_fifo_dout[95:64];
        y_d     = pix_fifo_dout[63:32];
        rgb_d   = pix_fifo_dout[31:0];
        state_d = CALC;
      end
      CALC: begin
        if (in_range) begin
          addr_d  = FB_BASE + (lin_idx << 2);
          data_d  = rgb_q;
          state_d = WRITE;
        end else begin
`ifdef GL_FB_CLIP_COUNT_EN
          clip_inc = 1'b1;
`endif
          state_d  = IDLE;
        end
      end
      WRITE: begin
        if (mem.mem_ack) state_d = IDLE;
      end
      CLEAR: begin
        if (mem.mem_ack) begin
          if (idx_q == PIX_LAST) begin
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + 32'd1;
            addr_d = addr_q + 32'd4;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rgb_q   <= rgb_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef GL_FB_CLIP_COUNT_EN
  always_comb begin
    clip_d = clip_q;
    if (clip_inc && !(&clip_q)) clip_d = clip_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) clip_q <= '0;
    else       clip_q <= clip_d;
  end

  assign clip_count = clip_q;
`endif

  assign busy         = (state_q != IDLE);
  assign mem.mem_req  = (state_q == WRITE) || (state_q == CLEAR);
  assign mem.mem_be   = {4{mem.mem_req}};
  assign mem.mem_addr = addr_q;
  assign mem.mem_data = data_q;

endmodule

`default_nettype wire
